// File: rtl/overlay_read_buffer_switcher_pkg.sv
// overlay_buf_pkg: shared sizes, FSM state type and index check for the overlay read buffer switcher
package overlay_buf_pkg;
  localparam int NUM_BUFS = 3;
  localparam int BUF_IDX_W = 2;
  localparam int SYNC_STAGES = 2;
  localparam int DROP_W = 16;
  typedef enum logic {EMPTY, READY} state_t;
  typedef logic [BUF_IDX_W-1:0] buf_idx_t;
  function automatic logic idx_valid(buf_idx_t i);
    return int'(i) < NUM_BUFS;
  endfunction
endpackage

// File: rtl/overlay_read_buffer_switcher_if.sv
// overlay_read_buffer_switcher_if: writer commit, VGA vsync and read-DMA buffer select bundle; master drives commits/vsync, slave is the switcher
interface overlay_read_buffer_switcher_if import overlay_buf_pkg::*; #(parameter int ADDR_W = 32);
  logic enable;
  buf_idx_t wr_buffer_port;
  logic wr_buffer_vsync;
  logic rd_vsync;
  buf_idx_t rd_buffer_port;
  logic [ADDR_W-1:0] rd_base;
  logic swap_pulse;
  logic pending;
  logic [DROP_W-1:0] drop_count;
  logic port_err;
  modport master(output enable, wr_buffer_port, wr_buffer_vsync, rd_vsync, input rd_buffer_port, rd_base, swap_pulse, pending, drop_count, port_err);
  modport slave(input enable, wr_buffer_port, wr_buffer_vsync, rd_vsync, output rd_buffer_port, rd_base, swap_pulse, pending, drop_count, port_err);
endinterface

// File: rtl/overlay_read_buffer_switcher_edge_sync_detect.sv
// edge_sync_detect: synchronizer plus history flop; ports clk, reset, i_async in, o_level synced level, o_edge one-cycle edge pulse
module edge_sync_detect import overlay_buf_pkg::*; #(
  parameter logic RST_VAL = 1'b0,
  parameter logic RISE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_edge
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_hist;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_edge = RISE ? (o_level & ~r_hist) : (~o_level & r_hist);
endmodule

// File: rtl/overlay_read_buffer_switcher.sv
// overlay_read_buffer_switcher: latches newest committed overlay buffer and hands it to the read DMA on VGA vsync; ports clk, reset, bus (slave)
module overlay_read_buffer_switcher import overlay_buf_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BUF0_BASE = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] BUF1_BASE = 32'h0004_B000,
  parameter logic [ADDR_W-1:0] BUF2_BASE = 32'h0009_6000
) (
  input logic clk,
  input logic reset,
  overlay_read_buffer_switcher_if.slave bus
);
  logic w_vs_edge, w_commit, w_unused_vs_lvl, w_unused_wr_lvl;
  logic w_commit_ok, w_take, w_swap;
  state_t r_state, w_state_nxt;
  buf_idx_t r_ready_buf, r_rd_port;
  logic [ADDR_W-1:0] r_rd_base, w_base;
  logic r_swap, r_err;
  logic [DROP_W-1:0] r_drop, w_drop_nxt;
  edge_sync_detect #(.RST_VAL(1'b1), .RISE(1'b0)) u_vs_sync (
    .clk(clk), .reset(reset), .i_async(bus.rd_vsync), .o_level(w_unused_vs_lvl), .o_edge(w_vs_edge)
  );
  edge_sync_detect #(.RST_VAL(1'b0), .RISE(1'b1)) u_wr_sync (
    .clk(clk), .reset(reset), .i_async(bus.wr_buffer_vsync), .o_level(w_unused_wr_lvl), .o_edge(w_commit)
  );
  // vsync consumes the old ready_buf before a same-cycle commit reloads it, so commit wins the state
  always_comb begin
    w_commit_ok = w_commit & idx_valid(bus.wr_buffer_port);
    w_take = w_vs_edge & (r_state == READY) & bus.enable;
    w_swap = w_take & (r_ready_buf != r_rd_port);
    w_state_nxt = w_commit_ok ? READY : w_take ? EMPTY : r_state;
    w_drop_nxt = (w_commit_ok & (r_state == READY) & ~w_vs_edge & ~&r_drop) ? r_drop + DROP_W'(1) : r_drop;
    w_base = (r_ready_buf == 2'd2) ? BUF2_BASE : (r_ready_buf == 2'd1) ? BUF1_BASE : BUF0_BASE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= EMPTY;
    else r_state <= w_state_nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_ready_buf <= '0;
      r_rd_port <= '0;
      r_rd_base <= BUF0_BASE;
      r_swap <= 1'b0;
      r_drop <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_commit_ok) r_ready_buf <= bus.wr_buffer_port;
      if (w_swap) begin
        r_rd_port <= r_ready_buf;
        r_rd_base <= w_base;
      end
      r_swap <= w_swap;
      r_drop <= w_drop_nxt;
      r_err <= r_err | (w_commit & ~w_commit_ok);
    end
  assign bus.rd_buffer_port = r_rd_port;
  assign bus.rd_base = r_rd_base;
  assign bus.swap_pulse = r_swap;
  assign bus.pending = (r_state == READY);
  assign bus.drop_count = r_drop;
  assign bus.port_err = r_err;
endmodule
